// File: rtl/ibex_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : ibex_register_file_mp
// Brief    : Multi-port flip-flop register file with optional write bypass,
//            registered error reporting and a sequential wipe engine.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_register_file_mp #(
   parameter int unsigned          AddrWidth   = 5,
   parameter int unsigned          DataWidth   = 32,
   parameter int unsigned          NumRead     = 2,
   parameter int unsigned          NumWrite    = 1,
   parameter bit                   WriteBypass = 1'b0,
   parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumRead*5-1:0]          raddr_i,
   output logic [NumRead*DataWidth-1:0]  rdata_o,
   input  logic [NumWrite*5-1:0]         waddr_i,
   input  logic [NumWrite*DataWidth-1:0] wdata_i,
   input  logic [NumWrite-1:0]           we_i,
   input  logic                          wipe_req_i,
   output logic                          wipe_busy_o,
   output logic                          wipe_done_o,
   output logic                          err_o
);

   localparam int unsigned          c_num_words = 2 ** AddrWidth;
   localparam logic [AddrWidth-1:0] c_last_addr = AddrWidth'(c_num_words - 1);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_wipe = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   // Word 0 has no storage; it is synthesised as a constant on every read port.
   logic [DataWidth-1:0] r_mem [1:c_num_words-1];
   logic [1:0]           r_state;
   logic [AddrWidth-1:0] r_cnt;
   logic                 r_err;

   logic                 w_busy;
   logic                 w_err;
   logic [4:0]           w_waddr [NumWrite];
   logic [DataWidth-1:0] w_wdata [NumWrite];
   logic [NumWrite-1:0]  w_in_range;
   logic [NumWrite-1:0]  w_valid;
   logic [NumWrite-1:0]  w_wen;

   assign w_busy = (r_state == c_st_wipe);

   generate
      for (genvar j = 0; j < NumWrite; j++) begin : g_wr
         assign w_waddr[j]    = waddr_i[5*j +: 5];
         assign w_wdata[j]    = wdata_i[DataWidth*j +: DataWidth];
         assign w_in_range[j] = (32'(w_waddr[j]) < c_num_words);
         assign w_valid[j]    = we_i[j] && w_in_range[j] && (w_waddr[j] != 5'd0);
         assign w_wen[j]      = w_valid[j] && !w_busy;
      end
   endgenerate

   generate
      for (genvar k = 0; k < NumRead; k++) begin : g_rd
         logic [4:0]           w_raddr;
         logic [DataWidth-1:0] w_rdata;

         assign w_raddr = raddr_i[5*k +: 5];

         // Out-of-range and zero addresses match no stored word and fall through
         // to WordZeroVal; bypass scans ascending so the highest port wins.
         always_comb begin
            w_rdata = WordZeroVal;
            for (int unsigned w = 1; w < c_num_words; w++) begin
               if (w_raddr == 5'(w)) begin
                  w_rdata = r_mem[AddrWidth'(w)];
               end
            end
            if (WriteBypass && !w_busy) begin
               for (int unsigned j = 0; j < NumWrite; j++) begin
                  if (w_valid[j] && (w_waddr[j] == w_raddr)) begin
                     w_rdata = w_wdata[j];
                  end
               end
            end
         end

         assign rdata_o[DataWidth*k +: DataWidth] = w_rdata;
      end
   endgenerate

   always_comb begin
      w_err = 1'b0;
      if (w_busy) begin
         w_err = |we_i;
      end else begin
         for (int unsigned j = 0; j < NumWrite; j++) begin
            if (we_i[j] && !w_in_range[j]) begin
               w_err = 1'b1;
            end
            for (int unsigned l = j + 1; l < NumWrite; l++) begin
               if (w_valid[j] && w_valid[l] && (w_waddr[j] == w_waddr[l])) begin
                  w_err = 1'b1;
               end
            end
         end
      end
   end

   // Later write ports are visited last, so their non-blocking update wins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 1; i < c_num_words; i++) begin
            r_mem[AddrWidth'(i)] <= WordZeroVal;
         end
      end else begin
         for (int unsigned i = 1; i < c_num_words; i++) begin
            if (w_busy && (r_cnt == AddrWidth'(i))) begin
               r_mem[AddrWidth'(i)] <= WordZeroVal;
            end else begin
               for (int unsigned j = 0; j < NumWrite; j++) begin
                  if (w_wen[j] && (w_waddr[j] == 5'(i))) begin
                     r_mem[AddrWidth'(i)] <= w_wdata[j];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= c_st_idle;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_err;
         case (r_state)
            c_st_idle: begin
               if (wipe_req_i) begin
                  r_state <= c_st_wipe;
                  r_cnt   <= AddrWidth'(1);
               end
            end
            c_st_wipe: begin
               if (r_cnt == c_last_addr) begin
                  r_state <= c_st_done;
               end else begin
                  r_cnt <= r_cnt + AddrWidth'(1);
               end
            end
            c_st_done: begin
               r_state <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign wipe_busy_o = w_busy;
   assign wipe_done_o = (r_state == c_st_done);
   assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ibex_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_register_file_mp
// Brief    : Checks two register-file configurations against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_register_file_mp;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: 32 words, 2 write ports, bypass on. Instance B: 16 words, 1 write port, no bypass.
   logic [4:0]  ra   [2][2];
   logic [4:0]  wa   [2][2];
   logic [31:0] wd   [2][2];
   logic        we   [2][2];
   logic        wreq [2];

   logic [9:0]  raddr_a, raddr_b, waddr_a;
   logic [63:0] rdata_a, rdata_b, wdata_a;
   logic [1:0]  we_a;
   logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [4:0]  waddr_b;
   logic [31:0] wdata_b;
   logic [0:0]  we_b;

   assign raddr_a = {ra[0][1], ra[0][0]};
   assign waddr_a = {wa[0][1], wa[0][0]};
   assign wdata_a = {wd[0][1], wd[0][0]};
   assign we_a    = {we[0][1], we[0][0]};
   assign raddr_b = {ra[1][1], ra[1][0]};
   assign waddr_b = wa[1][0];
   assign wdata_b = wd[1][0];
   assign we_b    = we[1][0];

   ibex_register_file_mp #(
      .AddrWidth(5), .DataWidth(32), .NumRead(2), .NumWrite(2), .WriteBypass(1'b1), .WordZeroVal('0)
   ) u_dut_a (
      .clk_i(clk), .rst_i(rst), .raddr_i(raddr_a), .rdata_o(rdata_a),
      .waddr_i(waddr_a), .wdata_i(wdata_a), .we_i(we_a), .wipe_req_i(wreq[0]),
      .wipe_busy_o(busy_a), .wipe_done_o(done_a), .err_o(err_a)
   );

   ibex_register_file_mp #(
      .AddrWidth(4), .DataWidth(32), .NumRead(2), .NumWrite(1), .WriteBypass(1'b0), .WordZeroVal('0)
   ) u_dut_b (
      .clk_i(clk), .rst_i(rst), .raddr_i(raddr_b), .rdata_o(rdata_b),
      .waddr_i(waddr_b), .wdata_i(wdata_b), .we_i(we_b), .wipe_req_i(wreq[1]),
      .wipe_busy_o(busy_b), .wipe_done_o(done_b), .err_o(err_b)
   );

   // Reference model: architectural register contents plus wipe progress.
   logic [31:0] mem  [2][32];
   bit          m_busy [2];
   bit          m_done [2];
   bit          m_err  [2];
   int          m_pos  [2];

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   function automatic int words(input int i);
      return (i == 0) ? 32 : 16;
   endfunction

   function automatic int nwr(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic bit legal(input int i, input int a);
      return (a != 0) && (a < words(i));
   endfunction

   function automatic logic [31:0] exp_read(input int i, input int k);
      int a = int'(ra[i][k]);
      logic [31:0] r = legal(i, a) ? mem[i][a] : 32'h0;
      if (i == 0 && !m_busy[i]) begin
         for (int j = 0; j < nwr(i); j++)
            if (we[i][j] && int'(wa[i][j]) == a && legal(i, a)) r = wd[i][j];
      end
      return r;
   endfunction

   function automatic logic [31:0] obs_read(input int i, input int k);
      return (i == 0) ? rdata_a[32*k +: 32] : rdata_b[32*k +: 32];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         string nm = (i == 0) ? "A" : "B";
         for (int k = 0; k < 2; k++)
            chk($sformatf("%s.rdata%0d(addr %0d)", nm, k, ra[i][k]), obs_read(i, k), exp_read(i, k));
         chk({nm, ".err"},  {31'b0, (i == 0) ? err_a  : err_b},  {31'b0, m_err[i]});
         chk({nm, ".busy"}, {31'b0, (i == 0) ? busy_a : busy_b}, {31'b0, m_busy[i]});
         chk({nm, ".done"}, {31'b0, (i == 0) ? done_a : done_b}, {31'b0, m_done[i]});
      end
   endtask

   task automatic model_tick();
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            for (int a = 0; a < 32; a++) mem[i][a] = 32'h0;
            m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0; m_pos[i] = 0;
         end else begin
            bit any_we = 0, bad = 0;
            for (int j = 0; j < nwr(i); j++) begin
               if (we[i][j]) any_we = 1;
               if (we[i][j] && int'(wa[i][j]) >= words(i)) bad = 1;
            end
            if (nwr(i) == 2 && we[i][0] && we[i][1] && wa[i][0] == wa[i][1] && legal(i, int'(wa[i][0])))
               bad = 1;
            m_err[i] = m_busy[i] ? any_we : bad;
            if (m_busy[i]) begin
               mem[i][m_pos[i]] = 32'h0;
               if (m_pos[i] == words(i) - 1) begin
                  m_busy[i] = 0; m_done[i] = 1;
               end else begin
                  m_pos[i]++;
               end
            end else begin
               for (int j = 0; j < nwr(i); j++)
                  if (we[i][j] && legal(i, int'(wa[i][j]))) mem[i][wa[i][j]] = wd[i][j];
               if (m_done[i]) m_done[i] = 0;
               else if (wreq[i]) begin
                  m_busy[i] = 1; m_pos[i] = 1;
               end
            end
         end
      end
   endtask

   task automatic step();
      #1;
      if (chk_en) check_all();
      model_tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic quiet();
      for (int i = 0; i < 2; i++) begin
         wreq[i] = 0;
         for (int j = 0; j < 2; j++) begin
            we[i][j] = 0; wa[i][j] = 0; wd[i][j] = 0; ra[i][j] = 0;
         end
      end
   endtask

   initial begin
      int bcnt;
      int dcnt;
      quiet();
      rst = 1;
      step();
      step();
      rst = 0;
      chk_en = 1;
      step();

      // Basic write then read, plus x0.
      we[0][0] = 1; wa[0][0] = 5; wd[0][0] = 32'hDEADBEEF;
      we[1][0] = 1; wa[1][0] = 5; wd[1][0] = 32'hCAFEF00D;
      step();
      quiet();
      ra[0][0] = 5; ra[0][1] = 0; ra[1][0] = 5; ra[1][1] = 0;
      step();

      // Same-cycle write/read: bypass on A, stored value on B.
      we[0][0] = 1; wa[0][0] = 7; wd[0][0] = 32'h1234; ra[0][0] = 7;
      we[1][0] = 1; wa[1][0] = 7; wd[1][0] = 32'h1234; ra[1][0] = 7;
      step();
      quiet();
      ra[0][0] = 7; ra[1][0] = 7;
      step();

      // Two-port conflict on A: higher port stored, bypass shows higher port.
      we[0][0] = 1; wa[0][0] = 9; wd[0][0] = 32'hA;
      we[0][1] = 1; wa[0][1] = 9; wd[0][1] = 32'hB; ra[0][0] = 9;
      step();
      quiet();
      ra[0][0] = 9;
      step();
      step();

      // Out-of-range write on B (16 words): address 20 must not alias x4.
      we[1][0] = 1; wa[1][0] = 4; wd[1][0] = 32'h4444_4444;
      step();
      we[1][0] = 1; wa[1][0] = 20; wd[1][0] = 32'h2020_2020; ra[1][0] = 20; ra[1][1] = 4;
      step();
      quiet();
      ra[1][0] = 20; ra[1][1] = 4;
      step();
      step();

      // Randomised traffic with occasional wipes.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 2; i++) begin
            wreq[i] = ($urandom_range(0, 39) == 0);
            for (int j = 0; j < 2; j++) begin
               ra[i][j] = 5'($urandom_range(0, 31));
               wa[i][j] = 5'($urandom_range(0, 31));
               wd[i][j] = $urandom;
               we[i][j] = ($urandom_range(0, 2) != 0) && (j < nwr(i));
            end
            if ($urandom_range(0, 3) == 0) wa[i][1] = wa[i][0];
            if ($urandom_range(0, 2) == 0) ra[i][0] = wa[i][0];
         end
         step();
      end
      quiet();
      for (int s = 0; s < 40; s++) step();

      // Fill every register, then wipe with a write injected mid-wipe.
      for (int a = 1; a < 32; a++) begin
         we[0][0] = 1; wa[0][0] = 5'(a); wd[0][0] = 32'h1000_0000 + a;
         we[1][0] = (a < 16); wa[1][0] = 5'(a); wd[1][0] = 32'h2000_0000 + a;
         step();
      end
      quiet();
      wreq[0] = 1; wreq[1] = 1;
      step();
      quiet();
      bcnt = 0; dcnt = 0;
      for (int c = 0; c < 36; c++) begin
         if (busy_a) bcnt++;
         if (done_a) dcnt++;
         if (c == 5) begin
            we[0][0] = 1; wa[0][0] = 30; wd[0][0] = 32'h5A5A5A5A; ra[0][0] = 30;
            we[1][0] = 1; wa[1][0] = 3;  wd[1][0] = 32'h5A5A5A5A;
         end else begin
            quiet();
            ra[0][0] = 5'(c % 32); ra[1][0] = 5'(c % 16);
         end
         step();
      end
      chk("A.wipe_busy_cycles", 32'(bcnt), 32'd31);
      chk("A.wipe_done_cycles", 32'(dcnt), 32'd1);
      quiet();
      for (int a = 0; a < 32; a += 2) begin
         ra[0][0] = 5'(a); ra[0][1] = 5'(a + 1); ra[1][0] = 5'(a); ra[1][1] = 5'(a + 1);
         step();
      end

      // Refill, start a wipe, reset at wipe cycle 10.
      for (int a = 1; a < 16; a++) begin
         we[0][0] = 1; wa[0][0] = 5'(a); wd[0][0] = $urandom;
         we[1][0] = 1; wa[1][0] = 5'(a); wd[1][0] = $urandom;
         step();
      end
      quiet();
      wreq[0] = 1; wreq[1] = 1;
      step();
      quiet();
      for (int c = 0; c < 10; c++) step();
      rst = 1;
      step();
      rst = 0;
      for (int a = 0; a < 32; a += 2) begin
         ra[0][0] = 5'(a); ra[0][1] = 5'(a + 1); ra[1][0] = 5'(a); ra[1][1] = 5'(a + 1);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
